// File: rtl/ahb_arbiter_if.sv
// rtl/ahb_arbiter_if.sv - bus-side signals of the four-master AHB arbiter
`timescale 1ns/1ps
interface ahb_arbiter_if;
    logic       hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4;
    logic       hlock_1, hlock_2, hlock_3, hlock_4;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic       hgrant_1, hgrant_2, hgrant_3, hgrant_4;
    logic [1:0] hmaster;
    logic       hmastlock;

    modport slave (
        input  hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4,
        input  hlock_1, hlock_2, hlock_3, hlock_4,
        input  htrans, hburst, hready,
        output hgrant_1, hgrant_2, hgrant_3, hgrant_4,
        output hmaster, hmastlock
    );

    modport master (
        output hbusreq_1, hbusreq_2, hbusreq_3, hbusreq_4,
        output hlock_1, hlock_2, hlock_3, hlock_4,
        output htrans, hburst, hready,
        input  hgrant_1, hgrant_2, hgrant_3, hgrant_4,
        input  hmaster, hmastlock
    );
endinterface

// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - four-master round-robin AHB arbiter with burst and lock hold
`timescale 1ns/1ps
module ahb_arbiter #(
    parameter int unsigned DEFAULT_MASTER = 0
) (
    input  logic          hclk,
    input  logic          hreset,
    ahb_arbiter_if.slave  bus
);
    localparam logic [1:0] DEF      = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_HOT  = 4'b0001 << DEF;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic [3:0] req, lock;
    logic [3:0] grant, grant_nxt;
    logic [1:0] rr_ptr, rr_nxt;
    logic [1:0] g;
    logic [3:0] burst_cnt, cnt_nxt;
    logic [3:0] beats_m1;
    logic [1:0] hmaster_q;
    logic       mastlock_q;
    logic       nonseq_acc, seq_acc, fixed, not_holding, arb_en;

    assign req  = {bus.hbusreq_4, bus.hbusreq_3, bus.hbusreq_2, bus.hbusreq_1};
    assign lock = {bus.hlock_4, bus.hlock_3, bus.hlock_2, bus.hlock_1};

    always_comb begin
        g = 2'd0;
        case (grant)
            4'b0010: g = 2'd1;
            4'b0100: g = 2'd2;
            4'b1000: g = 2'd3;
            default: g = 2'd0;
        endcase
    end

    always_comb begin
        beats_m1 = 4'd0;
        case (bus.hburst)
            3'b010, 3'b011: beats_m1 = 4'd3;
            3'b100, 3'b101: beats_m1 = 4'd7;
            3'b110, 3'b111: beats_m1 = 4'd15;
            default:        beats_m1 = 4'd0;
        endcase
    end

    assign nonseq_acc = bus.hready && (bus.htrans == T_NONSEQ);
    assign seq_acc    = bus.hready && (bus.htrans == T_SEQ);
    assign fixed      = (beats_m1 != 4'd0);

    always_comb begin
        cnt_nxt = burst_cnt;
        if (nonseq_acc)
            cnt_nxt = beats_m1;
        else if (seq_acc && burst_cnt != 4'd0)
            cnt_nxt = burst_cnt - 4'd1;
        else if (bus.hready && bus.htrans == T_IDLE)
            cnt_nxt = 4'd0;
    end

    // The bus may only move between bursts or on the final accepted SEQ beat.
    assign not_holding = ((burst_cnt == 4'd0) && !(nonseq_acc && fixed)) ||
                         ((burst_cnt == 4'd1) && seq_acc);
    assign arb_en = !lock[g] && not_holding && bus.hready;

    always_comb begin
        logic       found;
        logic [1:0] idx;
        found     = 1'b0;
        idx       = 2'd0;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        if (arb_en) begin
            grant_nxt = DEF_HOT;
            // i = 4 wraps to rr_ptr itself so a lone owner keeps the bus.
            for (int i = 1; i <= 4; i++) begin
                idx = rr_ptr + 2'(i);
                if (!found && req[idx]) begin
                    found     = 1'b1;
                    grant_nxt = 4'b0001 << idx;
                    rr_nxt    = idx;
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            grant      <= DEF_HOT;
            rr_ptr     <= DEF;
            burst_cnt  <= 4'd0;
            hmaster_q  <= DEF;
            mastlock_q <= 1'b0;
        end else begin
            grant     <= grant_nxt;
            rr_ptr    <= rr_nxt;
            burst_cnt <= cnt_nxt;
            if (bus.hready) begin
                hmaster_q  <= g;
                mastlock_q <= lock[g];
            end
        end
    end

    assign bus.hgrant_1  = grant[0];
    assign bus.hgrant_2  = grant[1];
    assign bus.hgrant_3  = grant[2];
    assign bus.hgrant_4  = grant[3];
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = mastlock_q;
endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
Four-master AHB bus arbiter. It samples the master requests and drives a one-hot grant. It also produces `hmaster[1:0]`, the select for the master-to-slave address/control mux. This is the master-side counterpart of the slave `sel`/`hsel` decoder. Arbitration is round-robin, fixed-length bursts and locked transfers are not broken, and ownership handover follows AHB `hready` timing.

Parameters:
- `DEFAULT_MASTER`, 0: index (0..3) granted when no master requests; also the reset owner.

Ports:
- `hclk`  in  1  bus clock; all state changes on rising edge.
- `hreset`  in  1  synchronous, active-high reset.
- `hbusreq_1..hbusreq_4`  in  1 each  bus request from masters 1..4 (index 0..3).
- `hlock_1..hlock_4`  in  1 each  locked-transfer request from masters 1..4.
- `htrans`  in  2  transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- `hburst`  in  3  burst type of the current owner (000 SINGLE, 001 INCR, 010/011 4-beat, 100/101 8-beat, 110/111 16-beat).
- `hready`  in  1  transfer done / bus ready.
- `hgrant_1..hgrant_4`  out  1 each  registered one-hot grant.
- `hmaster`  out  2  index of the address-phase owner.
- `hmastlock`  out  1  the current address-phase transfer is locked.

Behaviour:
Reset (`hreset` = 1 at a rising edge):
- `hgrant` = one-hot(`DEFAULT_MASTER`), `hmaster` = `DEFAULT_MASTER`, `hmastlock` = 0.
- `burst_cnt` = 0, `rr_ptr` = `DEFAULT_MASTER`.
- Reset mid-burst or mid-lock aborts it immediately with no residual hold.

Grant index and derived signals:
- `g` = index of the asserted `hgrant`.
- `accept` = `hready` & (`htrans` == NONSEQ or SEQ).

Burst counter (`burst_cnt`, 4 bits, remaining SEQ beats):
- `accept` & NONSEQ loads beats-1: 3, 7 or 15 for fixed bursts; 0 for SINGLE or INCR.
- `accept` & SEQ & `burst_cnt` > 0 decrements the counter.
- `hready` & `htrans` == IDLE clears it (early termination).
- BUSY, or `hready` = 0, holds it.
- A NONSEQ arriving while `burst_cnt` > 0 reloads the counter from the new `hburst`.

Arbitration enable (`arb_en`), all three must hold:
- `hlock` of master `g` is 0.
- The burst is not holding the bus: either `burst_cnt` == 0 and this cycle is not a fixed-burst NONSEQ `accept`, or `burst_cnt` == 1 and this cycle is a SEQ `accept` (last beat).
- `hready` = 1.

Round-robin selection when `arb_en` = 1:
- Search the requests starting from index (`rr_ptr`+1) mod 4, ascending with wrap.
- The first requester found becomes the next `hgrant` (registered, visible the next cycle), and `rr_ptr` <= that index.
- If no master requests, grant `DEFAULT_MASTER` and leave `rr_ptr` unchanged.
- If the current owner is the only requester, it keeps the grant.
- When `arb_en` = 0, `hgrant` and `rr_ptr` hold.

Ownership and lock:
- On `hready` = 1: `hmaster` <= `g` and `hmastlock` <= `hlock` of master `g`. With `hready` = 0 both hold.
- Ownership therefore moves one `hready` cycle after the grant changes, matching AHB address-phase handover.

Timing and invariants:
- Latency: request asserted at edge N with `arb_en` high → `hgrant` visible after edge N+1 → `hmaster` after the next edge with `hready` high.
- `hgrant` is always exactly one-hot; never zero or multiple bits.

Test Plan:
- Reset with `DEFAULT_MASTER` = 0 and all requests low → `hgrant_1` = 1, `hmaster` = 0, `hmastlock` = 0. Holding `hreset` high for 3 cycles keeps these values.
- Masters 1–4 all request continuously; master 1 issues IDLE and `hready` = 1 → grants rotate 2, 3, 4, 1 (`hmaster` 1, 2, 3, 0), one grant change per cycle.
- Master 2 is granted and issues NONSEQ with `hburst` = 011, then 3 SEQ beats with `hready` = 1, while master 3 requests → `hgrant_2` held until the 3rd SEQ is accepted. `hgrant_3` goes high the cycle after, and `hmaster` = 2 → `hmaster` = 3 after the next `hready`.
- Same burst with `hready` = 0 for 2 cycles mid-burst plus one BUSY cycle → `burst_cnt` holds through the stall and the BUSY; handover is delayed by exactly those 3 cycles.
- Master 4 holds `hlock_4` = 1 across 5 transfers while masters 1–3 request → `hgrant_4` stays high and `hmastlock` = 1 for the locked transfers. Dropping `hlock_4` → master 1 is granted next.
- Master 3 starts an INCR8, then `hreset` is pulsed after 2 beats → all outputs return to reset values, and a new request from master 2 is granted 1 cycle after reset deasserts.
